// File: rtl/muldiv_ex_ctrl.sv
// rtl/muldiv_ex_ctrl.sv - iterative multiply/divide sequencer with HI/LO and EX-stage stall
module muldiv_ex_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_a_raw;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_zdiv;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dz;

    logic                 w_accept;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_acc;
    logic [2*WIDTH-1:0]   w_neg_acc;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_accept = (r_state == S_IDLE) & start & ~flush;
    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed & opA[WIDTH-1]) ? -opA : opA;
    assign w_abs_b  = (w_signed & opB[WIDTH-1]) ? -opB : opB;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_acc = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: trial is WIDTH+1 bits wide because the shifted remainder can exceed WIDTH bits.
    assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_div_acc  = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_neg_acc = -r_acc;
    assign w_quot    = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 2'b00;
            r_opnd  <= '0;
            r_a_raw <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zdiv  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_a_raw <= opA;
                        r_neg_q <= w_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        r_neg_r <= w_signed & opA[WIDTH-1];
                        r_zdiv  <= op[1] & (opB == '0);
                        r_cnt   <= CNT_LAST;
                        r_opnd  <= op[1] ? w_abs_b : w_abs_a;
                        r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                    end
                end
                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_acc : w_mul_acc;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_op[1]) begin
                        {r_hi, r_lo} <= r_neg_q ? w_neg_acc : r_acc;
                        r_dz         <= 1'b0;
                    end else if (r_zdiv) begin
                        r_lo <= '1;
                        r_hi <= r_a_raw;
                        r_dz <= 1'b1;
                    end else begin
                        r_lo <= r_neg_q ? -w_quot : w_quot;
                        r_hi <= r_neg_r ? -w_rem : w_rem;
                        r_dz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | mf_req);
    assign done  = r_done;
    assign dz    = r_dz;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ex_ctrl.sv
// tb/tb_muldiv_ex_ctrl.sv - directed self-checking bench for muldiv_ex_ctrl
module tb_muldiv_ex_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_ex_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .mf_req (mf_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] i_op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = i_op;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int done_at, output int busy_cnt);
        done_at  = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
        end
    endtask

    // mf_at/flush_at: cycle index after acceptance (0 = first busy cycle), -1 disables.
    task automatic run_op(input string tag, input logic [1:0] i_op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dz, input int flush_at, input int mf_at, input logic mf_issue);
        int done_at;
        int busy_cnt;
        int unstable;
        int stall_err;
        logic exp_st;
        done_at   = -1;
        busy_cnt  = 0;
        unstable  = 0;
        stall_err = 0;
        @(negedge clk);
        op     = i_op;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        mf_req = mf_issue;
        #1;
        if (mf_issue) check({tag, "_stall_idle"}, {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        start  = 1'b0;
        mf_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mf_req = (mf_at >= 0) && (i >= mf_at);
            flush  = (i == flush_at);
            #1;
            if (busy) busy_cnt++;
            exp_st = (mf_at >= 0) && (i >= mf_at) && (i <= 32);
            if (stall !== exp_st) stall_err++;
            if (done) begin
                done_at = i;
                break;
            end
            if (hi !== m_hi || lo !== m_lo) unstable++;
        end
        mf_req = 1'b0;
        flush  = 1'b0;
        check({tag, "_latency"}, 64'(done_at), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_hilo_stable"}, 64'(unstable), 64'd0);
        if (mf_at >= 0) check({tag, "_stall"}, 64'(stall_err), 64'd0);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e_lo});
        check({tag, "_dz"}, {63'd0, dz}, {63'd0, e_dz});
        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        int done_at;
        int busy_cnt;
        n_checks = 0;
        n_errors = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        opA    = 32'd0;
        opB    = 32'd0;
        mf_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz", {63'd0, dz}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1, -1, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1, -1, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, -1, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0);
        run_op("divu_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, -1, 1'b1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, -1, -1, 1'b0);
        run_op("mf_stall", OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, -1, 5, 1'b0);

        // start killed by a same-cycle flush must not launch anything
        @(negedge clk);
        op    = OP_MULTU;
        opA   = 32'd9;
        opB   = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_issue_busy", {63'd0, busy}, 64'd0);
        check("flush_issue_hilo", {hi, lo}, {32'd0, 32'd30});

        run_op("flush_run", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 7, -1, 1'b0);

        // back-to-back: younger start held under stall, accepted in the done cycle
        issue(OP_MULTU, 32'd2, 32'd3);
        op    = OP_DIVU;
        opA   = 32'd50;
        opB   = 32'd7;
        start = 1'b1;
        @(negedge clk);
        #1;
        check("b2b_stall", {63'd0, stall}, 64'd1);
        wait_done(done_at, busy_cnt);
        check("b2b_first_latency", 64'(done_at), 64'd32);
        check("b2b_first_nostall", {63'd0, stall}, 64'd0);
        check("b2b_first_lo", {hi, lo}, {32'd0, 32'd6});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(done_at, busy_cnt);
        check("b2b_second_latency", 64'(done_at), 64'd33);
        check("b2b_second_busy", 64'(busy_cnt), 64'd33);
        check("b2b_second_hilo", {hi, lo}, {32'd1, 32'd7});

        // asynchronous reset in the middle of a run
        issue(OP_MULTU, 32'h0000_1234, 32'h0000_0010);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op("after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ex_ctrl.md
Name: muldiv_ex_ctrl

Overview:
- Iterative multiply/divide sequencer beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU issued from EX with forwarded operands, runs a 32-step radix-2 shift-add / restoring-divide loop, and writes the HI/LO registers.
- Asserts a pipeline stall when a younger muldiv or MFHI/MFLO instruction arrives while it is still running.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  muldiv instruction valid in EX this cycle
- flush  input  1  branch flush of the EX instruction; suppresses start in the same cycle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- opA  input  WIDTH  forwarded rs value (multiplicand / dividend)
- opB  input  WIDTH  forwarded rt value (multiplier / divisor)
- mf_req  input  1  MFHI/MFLO valid in EX this cycle
- busy  output  1  operation in progress
- stall  output  1  combinational: busy & (start | mf_req)
- done  output  1  one-cycle pulse; HI/LO hold the new result
- dz  output  1  divide-by-zero flag, updated together with done, held until the next done
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0, all internal operand/accumulator registers 0.
- Reset asserted mid-operation aborts it; HI/LO are cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE: on a clock edge with start=1 and flush=0:
  - latch op;
  - latch |opA|, |opB| for signed ops (raw values for unsigned ops);
  - latch neg_q = opA[31]^opB[31] and neg_r = opA[31] (both forced 0 for unsigned ops);
  - latch zdiv = (op[1] & opB==0);
  - counter=WIDTH-1; go to RUN.
- start with flush=1 is ignored.
- RUN, one iteration per cycle:
  - Multiply: if multiplier LSB=1, add multiplicand to the upper half of the 2*WIDTH accumulator; shift right 1.
  - Divide: shift the remainder:quotient pair left 1; trial subtract the divisor; on no borrow keep the difference and set quotient bit 1, else quotient bit 0.
  - counter decrements; when counter==0 the last iteration completes and the next state is FIX.
- FIX, one cycle:
  - Multiply: {hi,lo} <= neg_q ? -acc : acc (2*WIDTH two's-complement negate).
  - Divide: lo <= neg_q ? -quot : quot; hi <= neg_r ? -rem : rem.
  - Divide with zdiv: lo <= all ones; hi <= original opA. Sign fix is bypassed; dz <= 1.
  - All other ops: dz <= 0.
  - Next state IDLE; done=1 in the following cycle.
- Latency: start accepted at edge k; busy=1 for cycles k+1 through k+33 (32 RUN + 1 FIX); HI/LO updated at edge k+34; done=1 during cycle k+34 only. Divide-by-zero uses the same latency.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- hi/lo are stable while busy; they change only at the FIX edge or on reset.
- Stall:
  - A start or mf_req while busy asserts stall combinationally.
  - The pipeline holds the instruction; it is accepted at the first edge with busy=0.
  - The new start may be accepted in the same cycle done=1 (back-to-back), since busy=0 by then.
- flush while busy has no effect: the running instruction is older than the branch and completes.
- start and mf_req both high while IDLE: start is accepted; mf_req reads the current (old) HI/LO; no stall.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high exactly 33 cycles.
- MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, dz=1; a following DIVU 100/7 -> lo=14, hi=2, dz=0.
- MULT issued, then mf_req asserted 5 cycles later and held -> stall=1 until busy falls; hi/lo unchanged during stall.
- start with flush=1 -> busy stays 0, hi/lo unchanged; flush pulse during RUN -> result still written.
- rst_n pulsed low in RUN cycle 10 -> busy=0, hi=lo=0 immediately; next start runs a full 34-edge operation correctly.
